enable_pulse_gen: RTL and testbench

// Upstream stage for the enable-gated D flip-flop and register banks built on it.

---
 rtl/enable_pulse_gen.sv | 108 ++++++++++
 tb/tb_enable_pulse_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/enable_pulse_gen.sv
// Programmable clock-enable strobe generator: free-running periodic or counted burst.
module enable_pulse_gen #(
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [COUNT_W-1:0]  burst_len,
  output logic                enable,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  pulse_cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state, state_n;
  logic [PERIOD_W-1:0] cnt, cnt_n;
  logic [PERIOD_W-1:0] per_q, per_n;
  logic [COUNT_W-1:0]  len_q, len_n;
  logic                mode_q, mode_n;
  logic                enable_n, busy_n, done_n;
  logic [COUNT_W-1:0]  pulse_cnt_n;

  // Zero period / burst length are treated as one.
  logic [PERIOD_W-1:0] period_eff_c;
  logic [COUNT_W-1:0]  burst_eff_c;
  logic [COUNT_W-1:0]  pulse_inc_c;

  assign period_eff_c = (period == '0) ? PERIOD_W'(1) : period;
  assign burst_eff_c  = (burst_len == '0) ? COUNT_W'(1) : burst_len;
  assign pulse_inc_c  = pulse_cnt + COUNT_W'(1);

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      per_q     <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      enable    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      per_q     <= per_n;
      len_q     <= len_n;
      mode_q    <= mode_n;
      enable    <= enable_n;
      busy      <= busy_n;
      done      <= done_n;
      pulse_cnt <= pulse_cnt_n;
    end
  end

  // Next-state and next-output decode; stop takes priority over a due strobe.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    per_n       = per_q;
    len_n       = len_q;
    mode_n      = mode_q;
    enable_n    = 1'b0;
    busy_n      = busy;
    done_n      = 1'b0;
    pulse_cnt_n = pulse_cnt;

    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n     = RUN;
          per_n       = period_eff_c;
          len_n       = burst_eff_c;
          mode_n      = mode;
          cnt_n       = period_eff_c - PERIOD_W'(1);
          pulse_cnt_n = '0;
          busy_n      = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else if (cnt == '0) begin
          enable_n    = 1'b1;
          cnt_n       = per_q - PERIOD_W'(1);
          pulse_cnt_n = pulse_inc_c;
          if (mode_q && (pulse_inc_c == len_q)) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - PERIOD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_enable_pulse_gen.sv
// Randomized and directed bench for enable_pulse_gen against an edge-count reference model.
module tb_enable_pulse_gen;

  localparam int unsigned PW = 8;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode = 1'b0;
  logic [PW-1:0] period = '0;
  logic [CW-1:0] burst_len = '0;
  logic          enable, busy, done;
  logic [CW-1:0] pulse_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a strobe falls on every edge whose count since start is a multiple of P.
  bit m_run, m_mode, m_en, m_done;
  int m_k, m_p, m_l, m_cnt;

  enable_pulse_gen #(.PERIOD_W(PW), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .period(period), .burst_len(burst_len),
    .enable(enable), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  wire [10:0] dut_vec = {enable, busy, done, pulse_cnt};

  function automatic logic [10:0] exp_vec();
    return {m_en, m_run, m_done, CW'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_run = 0; m_mode = 0; m_en = 0; m_done = 0;
    m_k = 0; m_p = 1; m_l = 1; m_cnt = 0;
  endtask

  // Advance one rising edge, update the model from the inputs seen at that edge, settle.
  task automatic tick();
    @(posedge clk);
    m_en = 0;
    m_done = 0;
    if (rst) begin
      model_reset();
    end else if (!m_run) begin
      if (start && !stop) begin
        m_run = 1; m_k = 0; m_cnt = 0; m_mode = mode;
        m_p = (period == 0) ? 1 : int'(period);
        m_l = (burst_len == 0) ? 1 : int'(burst_len);
      end
    end else if (stop) begin
      m_run = 0;
    end else begin
      m_k++;
      if (m_k % m_p == 0) begin
        m_en = 1;
        m_cnt = (m_cnt + 1) % 256;
        if (m_mode && m_cnt == m_l) begin
          m_done = 1;
          m_run = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_init: got %h expected 000", dut_vec);
    end
    tick();
    rst = 1'b0;
    mode = 1'b0; period = 8'd4; start = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      start = 1'b0;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL reset_prerun cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    // Asynchronous reset mid-cycle while running.
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_async: got %h expected 000", dut_vec);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec() || enable !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_periodic();
    mode = 1'b0; period = 8'd3; start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      start = 1'b0;
      stop = (i == 14);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL periodic cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_burst();
    mode = 1'b1; period = 8'd2; burst_len = 8'd4; start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      start = 1'b0;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL burst cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (pulse_cnt !== 8'd4 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_final: got cnt=%0d busy=%b expected cnt=4 busy=0", pulse_cnt, busy);
    end
  endtask

  task automatic test_period_zero_stop();
    mode = 1'b0; period = 8'd0; start = 1'b1;
    for (int i = 0; i < 265; i++) begin
      tick();
      start = 1'b0;
      stop = (i == 261);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL period_zero cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    mode = 1'b1; period = 8'd1; burst_len = 8'd0; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start = (i < 2);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_ignore_changes();
    mode = 1'b0; period = 8'd2; start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      start = (i == 5);
      if (i == 3) period = 8'd7;
      if (i == 4) mode = 1'b1;
      stop = (i == 11);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL ignore_changes cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec() || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL start_stop_idle cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick();
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) period = PW'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) burst_len = CW'($urandom_range(0, 5));
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_burst();
    test_period_zero_stop();
    test_back_to_back();
    test_ignore_changes();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
